// File: rtl/gamecontrol_levels_pkg.sv
// gamecontrol_pkg: shared state/level encodings, scoring table and LFSR taps
package gamecontrol_pkg;

    typedef enum logic [2:0] {IDLE, READY, ISSUE, WAIT, DONE} state_t;

    typedef enum logic [1:0] {EASY = 2'd0, MEDIUM = 2'd1, HARD = 2'd2} level_t;

    // Points awarded per correct answer, two bits per level, EASY in the low slice
    localparam logic [5:0] POINTS = {2'd3, 2'd2, 2'd1};

    // x^8+x^6+x^5+x^4+1 in right-shifting Galois form
    localparam logic [7:0] LFSR_TAPS_8 = 8'hB8;

    // Maximal-length Galois tap masks for the supported generator widths
    function automatic logic [15:0] lfsr_taps(input int w);
        case (w)
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return {8'h00, LFSR_TAPS_8};
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            default: return 16'hD008;
        endcase
    endfunction

endpackage

// File: rtl/gamecontrol_levels_if.sv
// gamecontrol_if: player/session inputs and game status outputs of the game controller
interface gamecontrol_if #(parameter int SCORE_DIGITS = 2);

    logic                      logged_in;
    logic [1:0]                level;
    logic                      game_start;
    logic                      load;
    logic [3:0]                user_input;
    logic                      timeout;
    logic                      logout;
    logic                      reconfig;
    logic                      enable;
    logic [3:0]                number;
    logic [4*SCORE_DIGITS-1:0] score;
    logic                      correct;
    logic                      game_over;
    logic                      logout_from_gamecontrol;

    modport master (
        output logged_in, level, game_start, load, user_input, timeout, logout,
        input  reconfig, enable, number, score, correct, game_over, logout_from_gamecontrol
    );

    modport slave (
        input  logged_in, level, game_start, load, user_input, timeout, logout,
        output reconfig, enable, number, score, correct, game_over, logout_from_gamecontrol
    );

endinterface

// File: rtl/gamecontrol_levels_lfsr.sv
// morse_number_lfsr: free-running Galois LFSR supplying the low nibble as a random source
module morse_number_lfsr
    import gamecontrol_pkg::*;
#(
    parameter int                LFSR_W    = 8,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] value
);

    localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));

    logic [LFSR_W-1:0] lfsr_q, lfsr_d;

    // Shift right, folding the taps back in whenever a one falls off the end
    always_comb lfsr_d = lfsr_q[0] ? (lfsr_q >> 1) ^ TAPS : lfsr_q >> 1;

    // Advance every cycle; only reset interrupts the sequence
    always_ff @(posedge clk)
        lfsr_q <= !rst ? LFSR_SEED : lfsr_d;

    assign value = lfsr_q[3:0];

endmodule

// File: rtl/gamecontrol_levels.sv
// gamecontrol_levels: round sequencer issuing random digits and keeping a saturating BCD score
module gamecontrol_levels
    import gamecontrol_pkg::*;
#(
    parameter int                LFSR_W       = 8,
    parameter int                SCORE_DIGITS = 2,
    parameter int                ROUNDS       = 10,
    parameter logic [LFSR_W-1:0] LFSR_SEED    = 8'hA5
) (
    input  logic          clk,
    input  logic          rst,
    gamecontrol_if.slave  bus
);

    localparam int SW = 4 * SCORE_DIGITS;

    state_t         state_q;
    level_t         level_q;
    logic [7:0]     round_q;
    logic [3:0]     number_q, number_d;
    logic [SW-1:0]  score_q, score_d;
    logic           reconfig_q, enable_q, correct_q, game_over_q, ack_q;
    logic [3:0]     rnd;
    logic           hit, last;

    morse_number_lfsr #(.LFSR_W(LFSR_W), .LFSR_SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .value (rnd)
    );

    // Fold the random nibble into the digit range of the level
    function automatic logic [3:0] map_number(input logic [3:0] r, input level_t l);
        return l == EASY ? {2'b0, r[1:0]} : l == MEDIUM ? {1'b0, r[2:0]} : r < 4'd10 ? r : r - 4'd10;
    endfunction

    // Ripple BCD add of 1..3 points; a carry out of the top digit pins the score at all nines
    function automatic logic [SW-1:0] bcd_add(input logic [SW-1:0] s, input logic [1:0] p);
        logic [SW-1:0] r;
        logic [4:0]    t;
        logic          c;
        r = '0;
        t = '0;
        c = 1'b0;
        for (int i = 0; i < SCORE_DIGITS; i++) begin
            t = {1'b0, s[4*i +: 4]} + (i == 0 ? {3'b0, p} : {4'b0, c});
            c = t > 5'd9;
            r[4*i +: 4] = c ? t[3:0] - 4'd10 : t[3:0];
        end
        return c ? {SCORE_DIGITS{4'h9}} : r;
    endfunction

    // Candidate digit, candidate score and round bookkeeping for the current cycle
    always_comb begin
        number_d = map_number(rnd, level_q);
        score_d  = bcd_add(score_q, POINTS[{level_q, 1'b0} +: 2]);
        hit      = bus.load && bus.user_input == number_q;
        last     = round_q + 8'd1 == 8'(ROUNDS);
    end

    // Game FSM with all outputs registered; session loss outranks every game input
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            level_q     <= EASY;
            round_q     <= '0;
            number_q    <= '0;
            score_q     <= '0;
            reconfig_q  <= 1'b0;
            enable_q    <= 1'b0;
            correct_q   <= 1'b0;
            game_over_q <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            reconfig_q <= 1'b0;
            correct_q  <= 1'b0;
            ack_q      <= 1'b0;
            if (state_q != IDLE && (bus.logout || !bus.logged_in)) begin
                ack_q       <= bus.logout;
                state_q     <= IDLE;
                round_q     <= '0;
                number_q    <= '0;
                score_q     <= '0;
                enable_q    <= 1'b0;
                game_over_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (bus.logged_in) state_q <= READY;
                    READY, DONE: if (bus.game_start) begin
                        state_q     <= ISSUE;
                        round_q     <= '0;
                        score_q     <= '0;
                        level_q     <= level_t'(bus.level == 2'd3 ? 2'd2 : bus.level);
                        game_over_q <= 1'b0;
                    end
                    ISSUE: begin
                        number_q   <= number_d;
                        reconfig_q <= 1'b1;
                        enable_q   <= 1'b1;
                        state_q    <= WAIT;
                    end
                    WAIT: if (bus.load || bus.timeout) begin
                        round_q     <= round_q + 8'd1;
                        correct_q   <= hit;
                        score_q     <= hit ? score_d : score_q;
                        enable_q    <= 1'b0;
                        game_over_q <= last;
                        state_q     <= last ? DONE : ISSUE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.reconfig                = reconfig_q;
    assign bus.enable                  = enable_q;
    assign bus.number                  = number_q;
    assign bus.score                   = score_q;
    assign bus.correct                 = correct_q;
    assign bus.game_over               = game_over_q;
    assign bus.logout_from_gamecontrol = ack_q;

endmodule
